// File: rtl/ascii_key_pkg.sv
// Shared types and constants for the ASCII-to-PS/2 key sender.
// States, scan-code prefixes and small sequencing helpers used by the top.
package ascii_key_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SHIFT_MK  = 4'd1,
        EXT_MK    = 4'd2,
        MAKE      = 4'd3,
        EXT_BRK   = 4'd4,
        BRK_PFX   = 4'd5,
        BREAK     = 4'd6,
        SHIFT_PFX = 4'd7,
        SHIFT_BRK = 4'd8,
        GAP       = 4'd9
    } state_t;

    localparam logic [7:0] SC_SHIFT = 8'h12;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_NONE  = 8'h00;

    // True for every state that presents a byte on scan_out.
    function automatic logic is_byte_state(input state_t s);
        logic r;
        case (s)
            IDLE:    r = 1'b0;
            GAP:     r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // First byte state of a sequence for the given key attributes.
    function automatic state_t first_state(input logic shift, input logic ext);
        state_t r;
        if (shift) begin
            r = SHIFT_MK;
        end else if (ext) begin
            r = EXT_MK;
        end else begin
            r = MAKE;
        end
        return r;
    endfunction

    // Byte state following s; IDLE means the sequence is complete.
    function automatic state_t seq_after(input state_t s, input logic shift, input logic ext);
        state_t r;
        case (s)
            SHIFT_MK:  r = ext ? EXT_MK : MAKE;
            EXT_MK:    r = MAKE;
            MAKE:      r = ext ? EXT_BRK : BRK_PFX;
            EXT_BRK:   r = BRK_PFX;
            BRK_PFX:   r = BREAK;
            BREAK:     r = shift ? SHIFT_PFX : IDLE;
            SHIFT_PFX: r = SHIFT_BRK;
            SHIFT_BRK: r = IDLE;
            default:   r = IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ascii2key.sv
// Combinational ASCII -> PS/2 set-2 key lookup.
// Navigation keys (extended E0 codes) are mapped only when
// ASCII_KEY_SENDER_EXT_EN is defined; otherwise those codes are not found.
module ascii2key
    import ascii_key_pkg::*;
(
    input  logic [7:0] ascii,
    output logic       found,
    output logic       shift,
    output logic       ext,
    output logic [7:0] code
);

    logic       upper_s;
    logic [7:0] lower_s;

    // Fold upper-case letters onto lower case so letters share one table entry.
    always_comb begin
        if (ascii >= 8'h41 && ascii <= 8'h5A) begin
            upper_s = 1'b1;
            lower_s = ascii | 8'h20;
        end else begin
            upper_s = 1'b0;
            lower_s = ascii;
        end
    end

    // Key table: scan code plus shift/extended attributes.
    always_comb begin
        found = 1'b1;
        shift = upper_s;
        ext   = 1'b0;
        code  = SC_NONE;
        case (lower_s)
            8'h61: code = 8'h1C;  8'h62: code = 8'h32;  8'h63: code = 8'h21;
            8'h64: code = 8'h23;  8'h65: code = 8'h24;  8'h66: code = 8'h2B;
            8'h67: code = 8'h34;  8'h68: code = 8'h33;  8'h69: code = 8'h43;
            8'h6A: code = 8'h3B;  8'h6B: code = 8'h42;  8'h6C: code = 8'h4B;
            8'h6D: code = 8'h3A;  8'h6E: code = 8'h31;  8'h6F: code = 8'h44;
            8'h70: code = 8'h4D;  8'h71: code = 8'h15;  8'h72: code = 8'h2D;
            8'h73: code = 8'h1B;  8'h74: code = 8'h2C;  8'h75: code = 8'h3C;
            8'h76: code = 8'h2A;  8'h77: code = 8'h1D;  8'h78: code = 8'h22;
            8'h79: code = 8'h35;  8'h7A: code = 8'h1A;
            8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1E;
            8'h33: code = 8'h26;  8'h34: code = 8'h25;  8'h35: code = 8'h2E;
            8'h36: code = 8'h36;  8'h37: code = 8'h3D;  8'h38: code = 8'h3E;
            8'h39: code = 8'h46;
            8'h60: code = 8'h0E;  8'h2D: code = 8'h4E;  8'h3D: code = 8'h55;
            8'h5B: code = 8'h54;  8'h5D: code = 8'h5B;  8'h5C: code = 8'h5D;
            8'h3B: code = 8'h4C;  8'h27: code = 8'h52;  8'h2C: code = 8'h41;
            8'h2E: code = 8'h49;  8'h2F: code = 8'h4A;
            8'h29: begin shift = 1'b1; code = 8'h45; end
            8'h21: begin shift = 1'b1; code = 8'h16; end
            8'h40: begin shift = 1'b1; code = 8'h1E; end
            8'h23: begin shift = 1'b1; code = 8'h26; end
            8'h24: begin shift = 1'b1; code = 8'h25; end
            8'h25: begin shift = 1'b1; code = 8'h2E; end
            8'h5E: begin shift = 1'b1; code = 8'h36; end
            8'h26: begin shift = 1'b1; code = 8'h3D; end
            8'h2A: begin shift = 1'b1; code = 8'h3E; end
            8'h28: begin shift = 1'b1; code = 8'h46; end
            8'h7E: begin shift = 1'b1; code = 8'h0E; end
            8'h5F: begin shift = 1'b1; code = 8'h4E; end
            8'h2B: begin shift = 1'b1; code = 8'h55; end
            8'h7B: begin shift = 1'b1; code = 8'h54; end
            8'h7D: begin shift = 1'b1; code = 8'h5B; end
            8'h7C: begin shift = 1'b1; code = 8'h5D; end
            8'h3A: begin shift = 1'b1; code = 8'h4C; end
            8'h22: begin shift = 1'b1; code = 8'h52; end
            8'h3C: begin shift = 1'b1; code = 8'h41; end
            8'h3E: begin shift = 1'b1; code = 8'h49; end
            8'h3F: begin shift = 1'b1; code = 8'h4A; end
            8'h20: code = 8'h29;
            8'h0D: code = 8'h5A;
            8'h08: code = 8'h66;
            8'h09: code = 8'h0D;
            8'h1B: code = 8'h76;
`ifdef ASCII_KEY_SENDER_EXT_EN
            8'h02: begin ext = 1'b1; code = 8'h6C; end
            8'h03: begin ext = 1'b1; code = 8'h69; end
            8'h12: begin ext = 1'b1; code = 8'h75; end
            8'h11: begin ext = 1'b1; code = 8'h72; end
            8'h13: begin ext = 1'b1; code = 8'h6B; end
            8'h14: begin ext = 1'b1; code = 8'h74; end
            8'h01: begin ext = 1'b1; code = 8'h7D; end
            8'h04: begin ext = 1'b1; code = 8'h7A; end
            8'h18: begin ext = 1'b1; code = 8'h71; end
`endif
            default: begin
                found = 1'b0;
                shift = 1'b0;
                code  = SC_NONE;
            end
        endcase
    end

endmodule

// File: rtl/ascii_key_sender.sv
// ASCII character -> PS/2 set-2 make/break byte sequence generator.
// One character in flight at a time; GAP_CYCLES idle cycles between bytes.
// Optional macro ASCII_KEY_SENDER_EXT_EN enables E0-prefixed navigation keys.
module ascii_key_sender
    import ascii_key_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ascii_ready,
    output logic [7:0] scan_out,
    output logic       scan_valid,
    input  logic       scan_ready,
    output logic       busy,
    output logic       unmapped
);

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 32'd0) ? 16'(GAP_CYCLES - 32'd1) : 16'd0;

    logic       found_s;
    logic       shift_s;
    logic       ext_s;
    logic [7:0] code_s;

    state_t     state_r,   state_next_s;
    state_t     resume_r,  resume_next_s;
    state_t     succ_s;
    logic [15:0] gap_cnt_r, gap_cnt_next_s;
    logic       shift_r,   shift_next_s;
    logic       ext_r,     ext_next_s;
    logic [7:0] code_r,    code_next_s;
    logic       accept_s;

    logic       ready_r,    ready_next_s;
    logic       busy_r,     busy_next_s;
    logic       valid_r,    valid_next_s;
    logic [7:0] scan_r,     scan_next_s;
    logic       unmapped_r, unmapped_next_s;

    ascii2key u_lookup (
        .ascii (ascii_in),
        .found (found_s),
        .shift (shift_s),
        .ext   (ext_s),
        .code  (code_s)
    );

    assign accept_s    = ascii_valid & ready_r;
    assign ascii_ready = ready_r;
    assign busy        = busy_r;
    assign scan_valid  = valid_r;
    assign scan_out    = scan_r;
    assign unmapped    = unmapped_r;

    // FSM state, latched key attributes and gap counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            resume_r  <= IDLE;
            gap_cnt_r <= 16'd0;
            shift_r   <= 1'b0;
            ext_r     <= 1'b0;
            code_r    <= 8'h00;
        end else begin
            state_r   <= state_next_s;
            resume_r  <= resume_next_s;
            gap_cnt_r <= gap_cnt_next_s;
            shift_r   <= shift_next_s;
            ext_r     <= ext_next_s;
            code_r    <= code_next_s;
        end
    end

    // Next-state: accept in IDLE, advance on consumed byte, count out gaps.
    always_comb begin
        state_next_s   = state_r;
        resume_next_s  = resume_r;
        gap_cnt_next_s = gap_cnt_r;
        shift_next_s   = shift_r;
        ext_next_s     = ext_r;
        code_next_s    = code_r;
        succ_s         = seq_after(state_r, shift_r, ext_r);
        case (state_r)
            IDLE: begin
                if (accept_s && found_s) begin
                    shift_next_s = shift_s;
                    ext_next_s   = ext_s;
                    code_next_s  = code_s;
                    state_next_s = first_state(shift_s, ext_s);
                end else begin
                    state_next_s = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_r == 16'd0) begin
                    state_next_s = resume_r;
                end else begin
                    gap_cnt_next_s = gap_cnt_r - 16'd1;
                end
            end
`ifdef ASCII_KEY_SENDER_EXT_EN
            EXT_MK, EXT_BRK,
`endif
            SHIFT_MK, MAKE, BRK_PFX, BREAK, SHIFT_PFX, SHIFT_BRK: begin
                if (scan_ready && valid_r) begin
                    if (succ_s == IDLE) begin
                        state_next_s = IDLE;
                    end else if (GAP_CYCLES == 32'd0) begin
                        state_next_s = succ_s;
                    end else begin
                        state_next_s   = GAP;
                        resume_next_s  = succ_s;
                        gap_cnt_next_s = GAP_LAST;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered.
    always_comb begin
        ready_next_s    = (state_next_s == IDLE);
        busy_next_s     = (state_next_s != IDLE);
        valid_next_s    = is_byte_state(state_next_s);
        unmapped_next_s = accept_s & ~found_s;
        case (state_next_s)
            SHIFT_MK, SHIFT_BRK: scan_next_s = SC_SHIFT;
`ifdef ASCII_KEY_SENDER_EXT_EN
            EXT_MK, EXT_BRK:     scan_next_s = SC_EXT;
`endif
            MAKE, BREAK:         scan_next_s = code_next_s;
            BRK_PFX, SHIFT_PFX:  scan_next_s = SC_BREAK;
            default:             scan_next_s = SC_NONE;
        endcase
    end

    // Registered interface outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            scan_r     <= 8'h00;
            unmapped_r <= 1'b0;
        end else begin
            ready_r    <= ready_next_s;
            busy_r     <= busy_next_s;
            valid_r    <= valid_next_s;
            scan_r     <= scan_next_s;
            unmapped_r <= unmapped_next_s;
        end
    end

endmodule

// File: tb/tb_ascii_key_sender.sv
// Directed testbench for ascii_key_sender: instance 0 with GAP_CYCLES=0,
// instance 1 with GAP_CYCLES=16. Consumed bytes are logged with their cycle.
module tb_ascii_key_sender;

    logic       clk = 1'b0;
    logic       rst [2];
    logic [7:0] ain [2];
    logic       av  [2];
    logic       ar  [2];
    logic [7:0] so  [2];
    logic       sv  [2];
    logic       sr  [2];
    logic       bz  [2];
    logic       um  [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] rec_b [2][64];
    int         rec_c [2][64];
    int         rec_n [2] = '{0, 0};
    int         unm_n [2] = '{0, 0};

    always #5 clk = ~clk;

    ascii_key_sender #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst[0]), .ascii_in(ain[0]), .ascii_valid(av[0]),
        .ascii_ready(ar[0]), .scan_out(so[0]), .scan_valid(sv[0]),
        .scan_ready(sr[0]), .busy(bz[0]), .unmapped(um[0])
    );

    ascii_key_sender #(.GAP_CYCLES(16)) dut1 (
        .clk(clk), .reset(rst[1]), .ascii_in(ain[1]), .ascii_valid(av[1]),
        .ascii_ready(ar[1]), .scan_out(so[1]), .scan_valid(sv[1]),
        .scan_ready(sr[1]), .busy(bz[1]), .unmapped(um[1])
    );

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Log consumed bytes and unmapped pulses, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sv[i] && sr[i] && rec_n[i] < 64) begin
                rec_b[i][rec_n[i]] = so[i];
                rec_c[i][rec_n[i]] = cyc;
                rec_n[i] = rec_n[i] + 1;
            end
            if (um[i]) unm_n[i] = unm_n[i] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one character for one cycle; acc = cycle right after acceptance.
    task automatic send(input int w, input logic [7:0] ch, output int acc);
        check_eq($sformatf("ready_before_%0h", ch), {31'd0, ar[w]}, 32'd1);
        ain[w] = ch;
        av[w]  = 1'b1;
        @(posedge clk); #1;
        av[w]  = 1'b0;
        acc    = cyc;
    endtask

    // Wait (bounded) until n bytes have been logged for instance w.
    task automatic wait_bytes(input int w, input int n);
        int cnt;
        cnt = 0;
        while (rec_n[w] < n && cnt < 400) begin
            @(negedge clk); #1;
            cnt++;
        end
        check_eq("wait_bytes", rec_n[w], n);
    endtask

    // Compare logged bytes against seq (n bytes, first byte in the top used lane).
    task automatic check_seq(input string tag, input int w, input int base,
                             input logic [47:0] seq, input int n, input int gap, input int acc);
        logic [7:0] eb;
        check_eq({tag, "_count"}, rec_n[w] - base, n);
        for (int k = 0; k < n; k++) begin
            eb = seq[8*(n-1-k) +: 8];
            check_eq($sformatf("%s_b%0d", tag, k), {24'd0, rec_b[w][base+k]}, {24'd0, eb});
            if (gap >= 0) begin
                if (k == 0) check_eq({tag, "_lat"}, rec_c[w][base], acc);
                else check_eq($sformatf("%s_gap%0d", tag, k),
                              rec_c[w][base+k] - rec_c[w][base+k-1], gap + 1);
            end
        end
    endtask

    // Ready high / busy low one cycle after the last byte was consumed.
    task automatic check_done(input string tag, input int w);
        @(posedge clk); #1;
        check_eq({tag, "_ready"}, {31'd0, ar[w]}, 32'd1);
        check_eq({tag, "_busy"}, {31'd0, bz[w]}, 32'd0);
    endtask

    initial begin
        int acc, base, ubase;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; ain[i] = 8'h00; av[i] = 1'b0; sr[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, sv[1]}, 32'd0);
        check_eq("rst_scan",  {24'd0, so[1]}, 32'd0);
        check_eq("rst_busy",  {31'd0, bz[1]}, 32'd0);
        check_eq("rst_unmap", {31'd0, um[1]}, 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_ready0", {31'd0, ar[0]}, 32'd1);
        check_eq("post_rst_ready1", {31'd0, ar[1]}, 32'd1);

        // 'a' with no gap: 1C F0 1C on consecutive cycles.
        base = rec_n[0];
        send(0, 8'h61, acc);
        wait_bytes(0, base + 3);
        check_seq("a_gap0", 0, base, 48'h1CF01C, 3, 0, acc);
        check_done("a_gap0", 0);

        // 'A' with 16-cycle gaps.
        base = rec_n[1];
        send(1, 8'h41, acc);
        wait_bytes(1, base + 6);
        check_seq("A_gap16", 1, base, 48'h121CF01CF012, 6, 16, acc);
        check_done("A_gap16", 1);

        // 0x12: Up arrow when extended keys are enabled, else unmapped.
        base  = rec_n[0];
        ubase = unm_n[0];
        send(0, 8'h12, acc);
`ifdef ASCII_KEY_SENDER_EXT_EN
        wait_bytes(0, base + 5);
        check_seq("up_ext", 0, base, 48'hE075E0F075, 5, 0, acc);
        check_done("up_ext", 0);
`else
        check_eq("up_unmap_pulse", {31'd0, um[0]}, 32'd1);
        check_eq("up_unmap_valid", {31'd0, sv[0]}, 32'd0);
        check_eq("up_unmap_busy",  {31'd0, bz[0]}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("up_unmap_nobytes", rec_n[0] - base, 32'd0);
        check_eq("up_unmap_count", unm_n[0] - ubase, 32'd1);
`endif

        // 0x07 unmapped, then 'b' accepted on the very next cycle.
        base  = rec_n[0];
        ubase = unm_n[0];
        ain[0] = 8'h07; av[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("bel_unmap", {31'd0, um[0]}, 32'd1);
        check_eq("bel_ready", {31'd0, ar[0]}, 32'd1);
        check_eq("bel_valid", {31'd0, sv[0]}, 32'd0);
        ain[0] = 8'h62;
        @(posedge clk); #1;
        av[0] = 1'b0;
        acc = cyc;
        check_eq("b_unmap_low", {31'd0, um[0]}, 32'd0);
        wait_bytes(0, base + 3);
        check_seq("b_after_bel", 0, base, 48'h32F032, 3, 0, acc);
        check_eq("bel_unmap_count", unm_n[0] - ubase, 32'd1);
        check_done("b_after_bel", 0);

        // 'a' with scan_ready low for 5 cycles while byte 2 is offered.
        base = rec_n[0];
        send(0, 8'h61, acc);
        @(posedge clk); #1;
        sr[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("stall_valid%0d", k), {31'd0, sv[0]}, 32'd1);
            check_eq($sformatf("stall_byte%0d", k), {24'd0, so[0]}, 32'h0F0);
            @(posedge clk); #1;
        end
        sr[0] = 1'b1;
        wait_bytes(0, base + 3);
        check_seq("a_stall", 0, base, 48'h1CF01C, 3, -1, acc);
        check_done("a_stall", 0);

        // Reset in the middle of 'A' while byte 3 is being offered.
        base = rec_n[1];
        send(1, 8'h41, acc);
        wait_bytes(1, base + 2);
        @(posedge clk); #1;
        sr[1] = 1'b0;
        for (int k = 0; k < 40 && !sv[1]; k++) begin
            @(posedge clk); #1;
        end
        check_eq("midrst_pre_valid", {31'd0, sv[1]}, 32'd1);
        #2;
        rst[1] = 1'b1;
        #1;
        check_eq("midrst_valid", {31'd0, sv[1]}, 32'd0);
        check_eq("midrst_scan",  {24'd0, so[1]}, 32'd0);
        check_eq("midrst_busy",  {31'd0, bz[1]}, 32'd0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        sr[1]  = 1'b1;
        base = rec_n[1];
        repeat (40) @(posedge clk);
        #1;
        check_eq("midrst_no_resume", rec_n[1] - base, 32'd0);
        check_eq("midrst_idle_ready", {31'd0, ar[1]}, 32'd1);
        send(1, 8'h62, acc);
        wait_bytes(1, base + 3);
        check_seq("b_after_rst", 1, base, 48'h32F032, 3, 16, acc);
        check_done("b_after_rst", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
